dram_timing_memory: RTL and testbench
=====================================

Name: dram_timing_memory

Overview:
- Main-memory model that sits directly downstream of the cache and serves its memory-side port. Cache maddr/mout/mre/mwe connect to addr/din/re/we here; dout/ready here connect to the cache's min/mready.
- Word-addressed storage array behind a single-bank, open-page DRAM timing model: row hit, row empty and row conflict latencies, plus periodic refresh.
- Used for simulation and for memory-latency experiments.

Parameters:
- ADDR_WIDTH, 64, address width in bits (word address).
- WORD_WIDTH, 64, data word width in bits.
- DEPTH_BITS, 10, 2^n words of storage. addr[DEPTH_BITS-1:0] indexes the array; upper address bits are ignored.
- COL_BITS, 2, 2^n words per DRAM row. Row id = addr[DEPTH_BITS-1:COL_BITS].
- CAS_CYCLES, 2, column access latency, >=1.
- RCD_CYCLES, 3, activate latency, >=1.
- RP_CYCLES, 3, precharge latency, >=1.
- REFRESH_INTERVAL, 1024, cycles between refresh requests. 0 disables refresh.
- REFRESH_CYCLES, 4, refresh duration, >=1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- addr  input  ADDR_WIDTH  request word address.
- din  input  WORD_WIDTH  write data.
- dout  output  WORD_WIDTH  read data.
- re  input  1  read request.
- we  input  1  write request.
- ready  output  1  idle and able to accept a request; high also marks dout valid after a read.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, ready=1, dout=0, no row open, refresh counter=0, refresh_pending=0. Any in-flight write is discarded. The storage array is not reset; it initialises to zero for simulation.
- ready = (state==IDLE) && !refresh_pending. It is decoded from registers only and has no combinational path from re/we/addr.
- Accept: a request is accepted on the rising edge where ready && (re||we). At that edge addr, din and the operation are latched; inputs may change afterwards.
- re && we together is treated as a write. dout is unchanged.
- States: IDLE, PRECHARGE, ACTIVATE, ACCESS, REFRESH.
- Each non-IDLE state lasts exactly its parameter count of cycles, tracked by a down-counter loaded on entry.
- Transitions on accept:
  - Open row equals the request row (hit): go to ACCESS.
  - No row open (empty): go to ACTIVATE, then ACCESS.
  - A different row open (conflict): go to PRECHARGE, then ACTIVATE, then ACCESS.
- ACTIVATE completion records the open row. PRECHARGE completion clears it.
- Latency is the number of cycles ready is low after the accept edge:
  - hit: CAS_CYCLES
  - empty: RCD_CYCLES+CAS_CYCLES
  - conflict: RP_CYCLES+RCD_CYCLES+CAS_CYCLES
- ACCESS completion edge:
  - A read loads dout from the array.
  - A write stores the latched din.
  - The state returns to IDLE, so ready rises in the same cycle dout becomes valid.
- Open-page policy: the row stays open after an access.
- dout holds its value until the next completed read. Writes never change dout.
- Refresh counter:
  - Increments every cycle while REFRESH_INTERVAL != 0.
  - On reaching REFRESH_INTERVAL-1 it wraps to 0 and sets refresh_pending.
- A pending refresh is taken at the first edge with state==IDLE.
  - An access in progress finishes first.
  - No request can be accepted at that edge, because ready is already low.
- REFRESH: lasts REFRESH_CYCLES, closes the open row and clears refresh_pending on completion. A refresh request arriving while pending or refreshing is merged (no queueing).
- Reset asserted mid-operation: the operation is abandoned immediately with no array write, and all registers take their reset values.
- Requests while ready is low are ignored. The requester must hold re/we until ready is high.

Test Plan:
- Defaults with refresh disabled. After reset, write 0x1234 to addr 5 → ready low 5 cycles. Then read addr 5 → ready low 2 cycles, dout=0x1234 when ready rises.
- Read addr 6 (same row 1) → 2 cycles. Read addr 9 (row 2) → 8 cycles. Read addr 10 → 2 cycles, dout=0.
- Write 0xABCD to addr 7 and assert rst low during its ACCESS → ready=1 and dout=0 asynchronously. After release, read addr 7 → 5 cycles, dout=0.
- REFRESH_INTERVAL=20, idle → ready low exactly 4 cycles starting at cycle 20. Next access to the previously open row costs 5 cycles.
- Refresh due during a conflict access → the access completes with a full 8-cycle latency, refresh follows immediately with ready held low 4 more cycles, and the row is closed afterwards.
- Read addr 5 (dout=0x1234), then re=we=1, addr 5, din 0x55 → dout stays 0x1234. A subsequent read of addr 5 → dout=0x55.

Source files
------------

// File: rtl/dram_timing_memory.sv
// dram_timing_memory
//   Word-addressed main-memory model behind a single-bank, open-page DRAM
//   timing model. A request is served with row-hit, row-empty or
//   row-conflict latency. Refresh is issued periodically, and it closes the
//   open row.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-low reset
//   addr   request word address; addr[DEPTH_BITS-1:0] indexes storage
//   din    write data, captured on the accept edge
//   dout   read data, updated only when a read completes
//   re     read request (held until accepted)
//   we     write request; re && we together is a write
//   ready  idle and able to accept; also marks dout valid after a read
module dram_timing_memory #(
  parameter int ADDR_WIDTH       = 64,
  parameter int WORD_WIDTH       = 64,
  parameter int DEPTH_BITS       = 10,
  parameter int COL_BITS         = 2,
  parameter int CAS_CYCLES       = 2,
  parameter int RCD_CYCLES       = 3,
  parameter int RP_CYCLES        = 3,
  parameter int REFRESH_INTERVAL = 1024,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  re,
  input  logic                  we,
  output logic                  ready
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int ROW_W = DEPTH_BITS - COL_BITS;
  localparam int CNT_W = 16;
  localparam int REF_W = 32;

  // Counters are loaded with duration-1 and the state ends on the edge where
  // the counter is already zero, so a state lasts exactly its duration.
  localparam logic [CNT_W-1:0] CAS_LD = CNT_W'(CAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(RCD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(RP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REF_LD = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LAST =
    REF_W'((REFRESH_INTERVAL == 0) ? 0 : REFRESH_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECHARGE,
    S_ACTIVATE,
    S_ACCESS,
    S_REFRESH
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    cnt_done;
  logic                    row_open;
  logic [ROW_W-1:0]        open_row;
  logic                    req_wr;
  logic [DEPTH_BITS-1:0]   req_idx;
  logic [WORD_WIDTH-1:0]   req_data;
  logic [REF_W-1:0]        ref_cnt;
  logic                    ref_pending;
  logic                    ref_wrap;
  logic                    ref_due;
  logic                    accept;
  logic [ROW_W-1:0]        in_row;
  logic                    mem_we;
  logic                    unused_addr_hi;

  // Zero-initialised for simulation; never reset.
  logic [WORD_WIDTH-1:0]   mem [0:DEPTH-1] = '{default: '0};

  assign unused_addr_hi = ^addr[ADDR_WIDTH-1:DEPTH_BITS];

  assign in_row   = addr[DEPTH_BITS-1:COL_BITS];
  assign cnt_done = (cnt == '0);
  assign ready    = (state == S_IDLE) && !ref_pending;
  assign accept   = ready && (re || we);
  assign ref_wrap = (REFRESH_INTERVAL != 0) && (ref_cnt == REF_LAST);
  // A refresh request raised on this very edge counts as already pending.
  assign ref_due  = ref_pending || ref_wrap;
  assign mem_we   = rst && (state == S_ACCESS) && cnt_done && req_wr;

  // ---- refresh request generation ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (REFRESH_INTERVAL != 0)
        ref_cnt <= ref_wrap ? '0 : ref_cnt + REF_W'(1);
      // Requests arriving during a refresh are merged into it.
      if ((state == S_REFRESH) && cnt_done)
        ref_pending <= 1'b0;
      else if (ref_wrap && (state != S_REFRESH))
        ref_pending <= 1'b1;
    end
  end

  // ---- bank state machine ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      row_open <= 1'b0;
      open_row <= '0;
      req_wr   <= 1'b0;
      req_idx  <= '0;
      req_data <= '0;
      dout     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_wr   <= we;
            req_idx  <= addr[DEPTH_BITS-1:0];
            req_data <= din;
            if (row_open && (open_row == in_row)) begin
              state <= S_ACCESS;
              cnt   <= CAS_LD;
            end else if (!row_open) begin
              state <= S_ACTIVATE;
              cnt   <= RCD_LD;
            end else begin
              state <= S_PRECHARGE;
              cnt   <= RP_LD;
            end
          end else if (ref_due) begin
            state <= S_REFRESH;
            cnt   <= REF_LD;
          end
        end
        S_PRECHARGE: begin
          if (cnt_done) begin
            row_open <= 1'b0;
            state    <= S_ACTIVATE;
            cnt      <= RCD_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_ACTIVATE: begin
          if (cnt_done) begin
            row_open <= 1'b1;
            open_row <= req_idx[DEPTH_BITS-1:COL_BITS];
            state    <= S_ACCESS;
            cnt      <= CAS_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_ACCESS: begin
          if (cnt_done) begin
            if (!req_wr)
              dout <= mem[req_idx];
            // A refresh that came due during the access starts right away.
            if (ref_due) begin
              state <= S_REFRESH;
              cnt   <= REF_LD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_REFRESH: begin
          if (cnt_done) begin
            row_open <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- storage write ----
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[req_idx] <= req_data;
  end

endmodule

// File: tb/tb_dram_timing_memory.sv
module tb_dram_timing_memory;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [63:0] addr0, din0, dout0, addr1, din1, dout1;
  logic        re0, we0, ready0, re1, we1, ready1;
  int          cyc1;
  int          ntests = 0;
  int          nfail  = 0;

  always #5 clk = ~clk;

  // Instance 0: refresh disabled. Instance 1: refresh every 20 cycles.
  dram_timing_memory #(.REFRESH_INTERVAL(0)) dut0 (
    .clk(clk), .rst(rst0), .addr(addr0), .din(din0), .dout(dout0),
    .re(re0), .we(we0), .ready(ready0)
  );

  dram_timing_memory #(.REFRESH_INTERVAL(20)) dut1 (
    .clk(clk), .rst(rst1), .addr(addr1), .din(din1), .dout(dout1),
    .re(re1), .we(we1), .ready(ready1)
  );

  // Rising edges seen by instance 1 since its reset was released.
  always @(posedge clk) begin
    if (!rst1) cyc1 <= 0;
    else       cyc1 <= cyc1 + 1;
  end

  // Issue one request and return how many cycles ready stays low.
  task automatic op(input int sel, input logic r, input logic w,
                    input logic [63:0] a, input logic [63:0] d, output int lat);
    int waitc;
    lat = -1;
    @(negedge clk);
    waitc = 0;
    while (!((sel == 0) ? ready0 : ready1) && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 200) begin
      ntests++; nfail++;
      $display("FAIL op_wait_ready dut%0d ready stayed 0, required 1", sel);
      return;
    end
    if (sel == 0) begin re0 = r; we0 = w; addr0 = a; din0 = d; end
    else          begin re1 = r; we1 = w; addr1 = a; din1 = d; end
    @(posedge clk);
    #1;
    if (sel == 0) begin re0 = 1'b0; we0 = 1'b0; end
    else          begin re1 = 1'b0; we1 = 1'b0; end
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if ((sel == 0) ? ready0 : ready1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    ntests++;
    if (ready0 !== 1'b1) begin nfail++; $display("FAIL reset_ready0 got %b want 1", ready0); end
    ntests++;
    if (dout0 !== 64'd0) begin nfail++; $display("FAIL reset_dout0 got %h want 0", dout0); end
    ntests++;
    if (ready1 !== 1'b1) begin nfail++; $display("FAIL reset_ready1 got %b want 1", ready1); end
    ntests++;
    if (dout1 !== 64'd0) begin nfail++; $display("FAIL reset_dout1 got %h want 0", dout1); end
  endtask

  task automatic test_write_read();
    int lat;
    op(0, 1'b0, 1'b1, 64'd5, 64'h1234, lat);
    ntests++;
    if (lat !== 5) begin nfail++; $display("FAIL wr5_empty_lat got %0d want 5", lat); end
    op(0, 1'b1, 1'b0, 64'd5, 64'h0, lat);
    ntests++;
    if (lat !== 2) begin nfail++; $display("FAIL rd5_hit_lat got %0d want 2", lat); end
    ntests++;
    if (dout0 !== 64'h1234) begin nfail++; $display("FAIL rd5_data got %h want 1234", dout0); end
  endtask

  task automatic test_row_hit_conflict();
    int lat;
    op(0, 1'b1, 1'b0, 64'd6, 64'h0, lat);
    ntests++;
    if (lat !== 2) begin nfail++; $display("FAIL rd6_hit_lat got %0d want 2", lat); end
    op(0, 1'b1, 1'b0, 64'd9, 64'h0, lat);
    ntests++;
    if (lat !== 8) begin nfail++; $display("FAIL rd9_conflict_lat got %0d want 8", lat); end
    op(0, 1'b1, 1'b0, 64'd10, 64'h0, lat);
    ntests++;
    if (lat !== 2) begin nfail++; $display("FAIL rd10_hit_lat got %0d want 2", lat); end
    ntests++;
    if (dout0 !== 64'd0) begin nfail++; $display("FAIL rd10_data got %h want 0", dout0); end
  endtask

  task automatic test_reset_mid_access();
    int lat;
    op(0, 1'b1, 1'b0, 64'd5, 64'h0, lat);
    ntests++;
    if (lat !== 8) begin nfail++; $display("FAIL rd5_conflict_lat got %0d want 8", lat); end
    ntests++;
    if (dout0 !== 64'h1234) begin nfail++; $display("FAIL rd5_again_data got %h want 1234", dout0); end
    // Write to the open row (hit), then reset one cycle into its access.
    @(negedge clk);
    we0 = 1'b1; addr0 = 64'd7; din0 = 64'hABCD;
    @(posedge clk);
    #1;
    we0 = 1'b0;
    @(posedge clk);
    #1;
    ntests++;
    if (ready0 !== 1'b0) begin nfail++; $display("FAIL wr7_busy got ready %b want 0", ready0); end
    rst0 = 1'b0;
    #1;
    ntests++;
    if (ready0 !== 1'b1) begin nfail++; $display("FAIL async_rst_ready got %b want 1", ready0); end
    ntests++;
    if (dout0 !== 64'd0) begin nfail++; $display("FAIL async_rst_dout got %h want 0", dout0); end
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    op(0, 1'b1, 1'b0, 64'd7, 64'h0, lat);
    ntests++;
    if (lat !== 5) begin nfail++; $display("FAIL rd7_after_rst_lat got %0d want 5", lat); end
    ntests++;
    if (dout0 !== 64'd0) begin nfail++; $display("FAIL rd7_discarded_wr got %h want 0", dout0); end
  endtask

  task automatic test_read_write_both();
    int lat;
    op(0, 1'b1, 1'b0, 64'd5, 64'h0, lat);
    ntests++;
    if (dout0 !== 64'h1234) begin nfail++; $display("FAIL rw_pre_data got %h want 1234", dout0); end
    op(0, 1'b1, 1'b1, 64'd5, 64'h55, lat);
    ntests++;
    if (lat !== 2) begin nfail++; $display("FAIL rw_both_lat got %0d want 2", lat); end
    ntests++;
    if (dout0 !== 64'h1234) begin nfail++; $display("FAIL rw_both_dout got %h want 1234", dout0); end
    op(0, 1'b1, 1'b0, 64'd5, 64'h0, lat);
    ntests++;
    if (dout0 !== 64'h55) begin nfail++; $display("FAIL rw_post_data got %h want 55", dout0); end
  endtask

  // Random traffic in an untouched region with random ignored upper bits.
  task automatic test_random();
    logic [63:0] mem_m [int];
    int          open_row;
    logic [63:0] dout_m;
    int          idx, row, exp_lat, lat;
    logic        is_wr;
    logic [63:0] a, d;
    @(negedge clk);
    rst0 = 1'b0;
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    open_row = -1;
    dout_m   = 64'd0;
    for (int i = 0; i < 40; i++) begin
      idx   = 128 + $urandom_range(0, 63);
      a     = {$urandom, $urandom};
      a[9:0] = idx[9:0];
      d     = {$urandom, $urandom};
      is_wr = 1'($urandom_range(0, 1));
      row   = idx / 4;
      if (open_row == row)   exp_lat = 2;
      else if (open_row < 0) exp_lat = 5;
      else                   exp_lat = 8;
      op(0, !is_wr, is_wr, a, d, lat);
      open_row = row;
      if (is_wr) mem_m[idx] = d;
      else       dout_m = mem_m.exists(idx) ? mem_m[idx] : 64'd0;
      ntests++;
      if (lat !== exp_lat) begin
        nfail++; $display("FAIL rand_lat[%0d] got %0d want %0d", i, lat, exp_lat);
      end
      ntests++;
      if (dout0 !== dout_m) begin
        nfail++; $display("FAIL rand_dout[%0d] got %h want %h", i, dout0, dout_m);
      end
    end
  endtask

  task automatic test_refresh_idle();
    int lat, lowcnt, first_low;
    @(negedge clk);
    rst1 = 1'b1;
    op(1, 1'b0, 1'b1, 64'd5, 64'h1234, lat);
    ntests++;
    if (lat !== 5) begin nfail++; $display("FAIL ref_wr5_lat got %0d want 5", lat); end
    op(1, 1'b0, 1'b1, 64'd9, 64'h9999, lat);
    ntests++;
    if (lat !== 8) begin nfail++; $display("FAIL ref_wr9_lat got %0d want 8", lat); end
    while (cyc1 < 19) begin @(posedge clk); #1; end
    ntests++;
    if (ready1 !== 1'b1) begin nfail++; $display("FAIL ref_pre_ready got %b want 1", ready1); end
    lowcnt = 0; first_low = -1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (!ready1) begin
        if (first_low < 0) first_low = cyc1;
        lowcnt++;
      end
    end
    ntests++;
    if (lowcnt !== 4) begin nfail++; $display("FAIL ref_idle_len got %0d want 4", lowcnt); end
    ntests++;
    if (first_low !== 20) begin nfail++; $display("FAIL ref_idle_start got %0d want 20", first_low); end
    op(1, 1'b1, 1'b0, 64'd9, 64'h0, lat);
    ntests++;
    if (lat !== 5) begin nfail++; $display("FAIL ref_row_closed_lat got %0d want 5", lat); end
    ntests++;
    if (dout1 !== 64'h9999) begin nfail++; $display("FAIL ref_rd9_data got %h want 9999", dout1); end
  endtask

  task automatic test_refresh_conflict();
    int lat, dout_at;
    while (cyc1 < 35) begin @(posedge clk); #1; end
    @(negedge clk);
    ntests++;
    if (ready1 !== 1'b1) begin nfail++; $display("FAIL refc_pre_ready got %b want 1", ready1); end
    re1 = 1'b1; addr1 = 64'd5;
    @(posedge clk);
    #1;
    re1 = 1'b0;
    lat = -1; dout_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (dout_at < 0 && dout1 === 64'h1234) dout_at = k;
      if (ready1) begin lat = k; break; end
    end
    ntests++;
    if (dout_at !== 8) begin nfail++; $display("FAIL refc_access_lat got %0d want 8", dout_at); end
    ntests++;
    if (lat !== 12) begin nfail++; $display("FAIL refc_ready_low got %0d want 12", lat); end
    op(1, 1'b1, 1'b0, 64'd5, 64'h0, lat);
    ntests++;
    if (lat !== 5) begin nfail++; $display("FAIL refc_row_closed_lat got %0d want 5", lat); end
    ntests++;
    if (dout1 !== 64'h1234) begin nfail++; $display("FAIL refc_rd5_data got %h want 1234", dout1); end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    re0 = 1'b0; we0 = 1'b0; addr0 = '0; din0 = '0;
    re1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
    #2;
    rst0 = 1'b0; rst1 = 1'b0;
    test_reset();
    test_write_read();
    test_row_hit_conflict();
    test_reset_mid_access();
    test_read_write_both();
    test_random();
    test_refresh_idle();
    test_refresh_conflict();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
